netlist_eval_engine: RTL and testbench

- Streaming consumer of gate-level netlists. Applies primary-input values, accepts a topologically ordered stream of gate records (INV, NAND2, NOR2) and evaluates each one into an on-chip net-value array.
- Exposes any net value (primary outputs included) through a registered read port.
- Serves as the hardware evaluation back end for netlists produced by the team's parser and levelizer flow.

---
 rtl/netlist_eval_pkg.sv | 35 +++
 rtl/netlist_eval_engine_if.sv | 43 ++++
 rtl/gate_eval_cell.sv | 27 ++
 rtl/netlist_eval_engine.sv | 179 +++++++++++++++++
 tb/tb_netlist_eval_engine.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/netlist_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module   : netlist_eval_pkg
// Purpose  : Shared types and defaults for the netlist evaluation engine.
// Revision : 1.0
// ============================================================================
package netlist_eval_pkg;

    localparam int NET_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        GT_INV   = 2'd0,
        GT_NAND2 = 2'd1,
        GT_NOR2  = 2'd2,
        GT_RSVD  = 2'd3
    } gate_type_e;

    typedef enum logic [1:0] {
        EC_NONE       = 2'd0,
        EC_RSVD_TYPE  = 2'd1,
        EC_UNKNOWN_IN = 2'd2,
        EC_MULTI_DRV  = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EVAL = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/netlist_eval_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : netlist_eval_engine_if
// Purpose  : Load, gate-stream, read-back and status bundle of the engine.
// Revision : 1.0
// ============================================================================
interface netlist_eval_engine_if #(
    parameter int NET_W = netlist_eval_pkg::NET_W_DEFAULT,
    parameter int CNT_W = netlist_eval_pkg::CNT_W_DEFAULT
);
    logic             start;
    logic             pi_valid;
    logic [NET_W-1:0] pi_id;
    logic             pi_val;
    logic             load_done;
    logic             g_valid;
    logic             g_ready;
    logic [1:0]       g_type;
    logic [NET_W-1:0] g_out;
    logic [NET_W-1:0] g_a1;
    logic [NET_W-1:0] g_a2;
    logic             g_last;
    logic [NET_W-1:0] rd_id;
    logic             rd_val;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] gate_cnt;

    modport master (
        output start, pi_valid, pi_id, pi_val, load_done,
        output g_valid, g_type, g_out, g_a1, g_a2, g_last, rd_id,
        input  g_ready, rd_val, busy, done, err, err_code, gate_cnt
    );

    modport slave (
        input  start, pi_valid, pi_id, pi_val, load_done,
        input  g_valid, g_type, g_out, g_a1, g_a2, g_last, rd_id,
        output g_ready, rd_val, busy, done, err, err_code, gate_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gate_eval_cell.sv
`default_nettype none
// ============================================================================
// Module   : gate_eval_cell
// Purpose  : Combinational INV/NAND2/NOR2 evaluator with reserved-type flag.
// Revision : 1.0
// ============================================================================
module gate_eval_cell
    import netlist_eval_pkg::*;
(
    input  wire logic [1:0] g_type,
    input  wire logic       a1,
    input  wire logic       a2,
    output logic            zn,
    output logic            rsvd
);
    always_comb begin
        zn   = 1'b0;
        rsvd = 1'b0;
        case (gate_type_e'(g_type))
            GT_INV:   zn = ~a1;
            GT_NAND2: zn = ~(a1 & a2);
            GT_NOR2:  zn = ~(a1 | a2);
            default:  rsvd = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/netlist_eval_engine.sv
`default_nettype none
// ============================================================================
// Module   : netlist_eval_engine
// Purpose  : Loads primary inputs, evaluates a levelized gate stream into a
//            net array and exposes any net through a registered read port.
//            Optional NETEVAL_XCHECK_EN adds known-bit input/driver checks.
// Revision : 1.0
// ============================================================================
module netlist_eval_engine
    import netlist_eval_pkg::*;
#(
    parameter int NET_W    = NET_W_DEFAULT,
    parameter int NUM_NETS = 2**NET_W,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input wire logic clk,
    input wire logic rst,
    netlist_eval_engine_if.slave bus
);
    state_e              state_q, state_d;
    logic [NUM_NETS-1:0] net_q, net_d;
    logic [CNT_W-1:0]    gate_cnt_q, gate_cnt_d;
    err_code_e           err_code_q, err_code_d;
    logic                g_ready_q, g_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                rd_val_q, rd_val_d;

    logic                accept;
    logic                zn;
    logic                rsvd;
    err_code_e           gate_err;

    function automatic logic in_range(input logic [NET_W-1:0] id);
        return int'(id) < NUM_NETS;
    endfunction

    function automatic logic bit_rd(input logic [NUM_NETS-1:0] arr, input logic [NET_W-1:0] id);
        return in_range(id) ? arr[id] : 1'b0;
    endfunction

    gate_eval_cell u_gate_eval_cell (
        .g_type (bus.g_type),
        .a1     (bit_rd(net_q, bus.g_a1)),
        .a2     (bit_rd(net_q, bus.g_a2)),
        .zn     (zn),
        .rsvd   (rsvd)
    );

    assign accept = (state_q == ST_EVAL) && bus.g_valid && g_ready_q;

`ifdef NETEVAL_XCHECK_EN
    logic [NUM_NETS-1:0] known_q, known_d;
    logic                a1_unknown, a2_unknown, out_driven;

    // INV ignores A2, so only two-input gates demand a known A2.
    assign a1_unknown = ~bit_rd(known_q, bus.g_a1);
    assign a2_unknown = ((bus.g_type == GT_NAND2) || (bus.g_type == GT_NOR2))
                        && ~bit_rd(known_q, bus.g_a2);
    assign out_driven = bit_rd(known_q, bus.g_out);
`endif

    always_comb begin
        gate_err = EC_NONE;
        if (rsvd) begin
            gate_err = EC_RSVD_TYPE;
        end
`ifdef NETEVAL_XCHECK_EN
        else if (a1_unknown || a2_unknown) begin
            gate_err = EC_UNKNOWN_IN;
        end else if (out_driven) begin
            gate_err = EC_MULTI_DRV;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        net_d      = net_q;
        gate_cnt_d = gate_cnt_q;
        err_code_d = err_code_q;
`ifdef NETEVAL_XCHECK_EN
        known_d    = known_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) begin
                    state_d    = ST_LOAD;
                    net_d      = '0;
                    gate_cnt_d = '0;
                    err_code_d = EC_NONE;
`ifdef NETEVAL_XCHECK_EN
                    known_d    = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (bus.pi_valid && in_range(bus.pi_id)) begin
                    net_d[bus.pi_id] = bus.pi_val;
`ifdef NETEVAL_XCHECK_EN
                    known_d[bus.pi_id] = 1'b1;
`endif
                end
                if (bus.load_done) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (accept) begin
                    if (gate_err != EC_NONE) begin
                        state_d    = ST_ERR;
                        err_code_d = gate_err;
                    end else begin
                        if (in_range(bus.g_out)) begin
                            net_d[bus.g_out] = zn;
`ifdef NETEVAL_XCHECK_EN
                            known_d[bus.g_out] = 1'b1;
`endif
                        end
                        if (!(&gate_cnt_q)) begin
                            gate_cnt_d = gate_cnt_q + CNT_W'(1);
                        end
                        if (bus.g_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered from the next state so they align with it.
        g_ready_d = (state_d == ST_EVAL);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_EVAL);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
        rd_val_d  = bit_rd(net_q, bus.rd_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            net_q      <= '0;
            gate_cnt_q <= '0;
            err_code_q <= EC_NONE;
            g_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_val_q   <= 1'b0;
`ifdef NETEVAL_XCHECK_EN
            known_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            net_q      <= net_d;
            gate_cnt_q <= gate_cnt_d;
            err_code_q <= err_code_d;
            g_ready_q  <= g_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_val_q   <= rd_val_d;
`ifdef NETEVAL_XCHECK_EN
            known_q    <= known_d;
`endif
        end
    end

    assign bus.g_ready  = g_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.gate_cnt = gate_cnt_q;
    assign bus.rd_val   = rd_val_q;
endmodule
`default_nettype wire

// File: tb/tb_netlist_eval_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_netlist_eval_engine
// Purpose  : Scoreboard bench for netlist_eval_engine with a net-array model.
// Revision : 1.0
// ============================================================================
module tb_netlist_eval_engine;
    localparam int NET_W = 8;
    localparam int NN    = 256;
    localparam int CNT_W = 16;

    localparam int K_RD = 0, K_DONE = 1, K_ERR = 2, K_CODE = 3, K_CNT = 4, K_BUSY = 5, K_RDY = 6;
    localparam int S_IDLE = 0, S_LOAD = 1, S_EVAL = 2, S_DONE = 3, S_ERR = 4;

    logic clk = 1'b0;
    logic rst;

    netlist_eval_engine_if #(.NET_W(NET_W), .CNT_W(CNT_W)) bus_if ();

    netlist_eval_engine #(.NET_W(NET_W), .NUM_NETS(NN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Behavioural model of the engine's observable state.
    bit m_net   [NN];
    bit m_known [NN];
    int m_state;
    int m_code;
    int m_cnt;
    int stalls;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          due;
    } sb_t;
    sb_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_next(input string name, input int kind, input logic [31:0] exp);
        sb.push_back('{name, kind, exp, cyc + 1});
    endtask

    function automatic logic [31:0] dut_field(input int kind);
        case (kind)
            K_RD:    return 32'(bus_if.rd_val);
            K_DONE:  return 32'(bus_if.done);
            K_ERR:   return 32'(bus_if.err);
            K_CODE:  return 32'(bus_if.err_code);
            K_CNT:   return 32'(bus_if.gate_cnt);
            K_BUSY:  return 32'(bus_if.busy);
            K_RDY:   return 32'(bus_if.g_ready);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    initial begin : monitor
        sb_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check(e.name, dut_field(e.kind), e.exp);
            end
        end
    end

    task automatic drive_idle();
        bus_if.start     = 1'b0;
        bus_if.pi_valid  = 1'b0;
        bus_if.pi_id     = '0;
        bus_if.pi_val    = 1'b0;
        bus_if.load_done = 1'b0;
        bus_if.g_valid   = 1'b0;
        bus_if.g_type    = '0;
        bus_if.g_out     = '0;
        bus_if.g_a1      = '0;
        bus_if.g_a2      = '0;
        bus_if.g_last    = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NN; i++) begin
            m_net[i]   = 1'b0;
            m_known[i] = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        drive_idle();
        bus_if.start = 1'b1;
        @(posedge clk);
        if (m_state == S_IDLE || m_state == S_DONE || m_state == S_ERR) begin
            model_clear();
            m_state = S_LOAD;
            m_code  = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic load_pi(input int id, input bit val, input bit fin);
        @(negedge clk);
        drive_idle();
        bus_if.pi_valid  = 1'b1;
        bus_if.pi_id     = NET_W'(id);
        bus_if.pi_val    = val;
        bus_if.load_done = fin;
        @(posedge clk);
        if (m_state == S_LOAD) begin
            m_net[id]   = val;
            m_known[id] = 1'b1;
            if (fin) m_state = S_EVAL;
        end
    endtask

    task automatic load_end();
        @(negedge clk);
        drive_idle();
        bus_if.load_done = 1'b1;
        @(posedge clk);
        if (m_state == S_LOAD) m_state = S_EVAL;
    endtask

    // Start and PI write during EVAL, both of which must be ignored.
    task automatic poke_ignored(input int id, input bit val);
        @(negedge clk);
        drive_idle();
        bus_if.start    = 1'b1;
        bus_if.pi_valid = 1'b1;
        bus_if.pi_id    = NET_W'(id);
        bus_if.pi_val   = val;
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
        @(posedge clk);
    endtask

    task automatic send_gate(input int t, input int o, input int a1, input int a2, input bit last,
                             output int ec);
        int waits;
        bit x;
        bit y;
        bit v;
        @(negedge clk);
        drive_idle();
        bus_if.g_valid = 1'b1;
        bus_if.g_type  = 2'(t);
        bus_if.g_out   = NET_W'(o);
        bus_if.g_a1    = NET_W'(a1);
        bus_if.g_a2    = NET_W'(a2);
        bus_if.g_last  = last;
        waits = 0;
        while (!bus_if.g_ready && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        stalls += waits;
        if (!bus_if.g_ready) check("g_ready_timeout", 32'(bus_if.g_ready), 32'd1);
        @(posedge clk);
        ec = 0;
        if (m_state == S_EVAL) begin
            x = m_net[a1];
            y = m_net[a2];
            case (t)
                0:       v = !x;
                1:       v = !(x && y);
                default: v = !(x || y);
            endcase
            if (t == 3) ec = 1;
`ifdef NETEVAL_XCHECK_EN
            if (ec == 0 && (!m_known[a1] || (t != 0 && !m_known[a2]))) ec = 2;
            if (ec == 0 && m_known[o]) ec = 3;
`endif
            if (ec != 0) begin
                m_state = S_ERR;
                m_code  = ec;
            end else begin
                m_net[o]   = v;
                m_known[o] = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (last) m_state = S_DONE;
            end
        end
    endtask

    task automatic status_chk(input string pfx);
        @(negedge clk);
        drive_idle();
        expect_next({pfx, "_done"}, K_DONE, 32'(m_state == S_DONE));
        expect_next({pfx, "_err"},  K_ERR,  32'(m_state == S_ERR));
        expect_next({pfx, "_code"}, K_CODE, 32'(m_code));
        expect_next({pfx, "_cnt"},  K_CNT,  32'(m_cnt));
        expect_next({pfx, "_busy"}, K_BUSY, 32'(m_state == S_LOAD || m_state == S_EVAL));
        expect_next({pfx, "_rdy"},  K_RDY,  32'(m_state == S_EVAL));
        @(posedge clk);
    endtask

    task automatic read_chk(input int id, input string pfx);
        @(negedge clk);
        drive_idle();
        bus_if.rd_id = NET_W'(id);
        expect_next($sformatf("%s_n%0d", pfx, id), K_RD, 32'(m_net[id]));
        @(posedge clk);
    endtask

    task automatic run_random(input int runs);
        int pool[$];
        int n_pi;
        int n_g;
        int t;
        int a1;
        int a2;
        int ec;
        for (int r = 0; r < runs; r++) begin
            pool.delete();
            do_start();
            n_pi = $urandom_range(2, 6);
            for (int i = 0; i < n_pi; i++) begin
                pool.push_back($urandom_range(1, 40));
                load_pi(pool[i], 1'($urandom_range(0, 1)), (i == n_pi - 1) && r[0]);
            end
            if (!r[0]) load_end();
            n_g = $urandom_range(3, 12);
            for (int g = 0; g < n_g; g++) begin
                t  = ($urandom_range(0, 29) == 0) ? 3 : int'($urandom_range(0, 2));
                a1 = pool[$urandom_range(0, pool.size() - 1)];
                a2 = pool[$urandom_range(0, pool.size() - 1)];
                if ($urandom_range(0, 19) == 0) a1 = $urandom_range(200, 255);
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_gate(t, 64 + g, a1, a2, g == n_g - 1, ec);
                pool.push_back(64 + g);
                if (ec != 0) break;
            end
            status_chk($sformatf("rnd%0d", r));
            foreach (pool[i]) read_chk(pool[i], $sformatf("rnd%0d", r));
        end
    endtask

    int gate_set [10][5];

    initial begin : driver
        int ec;
        rst = 1'b1;
        drive_idle();
        bus_if.rd_id = '0;
        model_clear();
        m_state = S_IDLE;
        m_code  = 0;
        m_cnt   = 0;
        stalls  = 0;

        status_chk("reset");
        read_chk(0, "reset");
        @(negedge clk);
        rst = 1'b0;

        // Reference netlist: {type, out, a1, a2, last}.
        gate_set = '{'{0, 4, 1, 0, 0}, '{0, 5, 2, 0, 0}, '{1, 6, 4, 5, 0}, '{0, 7, 5, 0, 0},
                     '{2, 8, 4, 3, 0}, '{0, 9, 6, 0, 0}, '{2, 10, 6, 7, 0}, '{1, 11, 7, 8, 0},
                     '{2, 12, 9, 10, 0}, '{2, 13, 10, 8, 1}};
        do_start();
        load_pi(1, 1'b0, 1'b0);
        load_pi(2, 1'b1, 1'b0);
        load_pi(3, 1'b0, 1'b0);
        load_end();
        for (int i = 0; i < 10; i++)
            send_gate(gate_set[i][0], gate_set[i][1], gate_set[i][2], gate_set[i][3],
                      gate_set[i][4] != 0, ec);
        status_chk("gates");
        for (int id = 4; id <= 13; id++) read_chk(id, "gates");

        // Back-to-back dependent INVs; n1 written together with load_done.
        do_start();
        load_pi(1, 1'b1, 1'b1);
        stalls = 0;
        send_gate(0, 4, 1, 0, 1'b0, ec);
        send_gate(0, 5, 4, 0, 1'b1, ec);
        check("b2b_stall", 32'(stalls), 32'd0);
        status_chk("b2b");
        read_chk(1, "b2b");
        read_chk(5, "b2b");

        // Reserved type on the third gate, then restart from ERR.
        do_start();
        load_pi(1, 1'b1, 1'b0);
        load_pi(2, 1'b0, 1'b1);
        send_gate(1, 3, 1, 2, 1'b0, ec);
        send_gate(2, 4, 1, 3, 1'b0, ec);
        send_gate(3, 5, 1, 2, 1'b0, ec);
        status_chk("rsvd");
        read_chk(5, "rsvd");
        do_start();
        status_chk("rsvd_restart");
        load_pi(1, 1'b1, 1'b1);
        send_gate(0, 2, 1, 0, 1'b1, ec);
        status_chk("rsvd_after");

        // Gate reading a net that was never loaded.
        do_start();
        load_pi(1, 1'b1, 1'b1);
        send_gate(0, 4, 200, 0, 1'b0, ec);
        if (ec == 0) send_gate(1, 5, 4, 1, 1'b1, ec);
        status_chk("unloaded");
        read_chk(4, "unloaded");
        read_chk(5, "unloaded");

        // Second driver of n4.
        do_start();
        load_pi(1, 1'b1, 1'b1);
        send_gate(0, 4, 1, 0, 1'b0, ec);
        if (ec == 0) send_gate(0, 4, 4, 0, 1'b1, ec);
        status_chk("redrive");
        read_chk(4, "redrive");

        // Gate overdriving a primary input.
        do_start();
        load_pi(1, 1'b1, 1'b0);
        load_pi(2, 1'b1, 1'b1);
        send_gate(0, 2, 1, 0, 1'b1, ec);
        status_chk("pi_drive");
        read_chk(2, "pi_drive");

        // Start and PI write during EVAL are ignored.
        do_start();
        load_pi(1, 1'b1, 1'b0);
        load_pi(2, 1'b0, 1'b1);
        send_gate(1, 3, 1, 2, 1'b0, ec);
        poke_ignored(2, 1'b1);
        send_gate(2, 4, 3, 2, 1'b1, ec);
        status_chk("ign_start");
        read_chk(2, "ign_start");
        read_chk(4, "ign_start");

        run_random(12);

        // Asynchronous reset in the middle of EVAL after four gates.
        do_start();
        load_pi(1, 1'b1, 1'b0);
        load_pi(2, 1'b0, 1'b1);
        bus_if.rd_id = NET_W'(1);
        send_gate(0, 10, 2, 0, 1'b0, ec);
        send_gate(1, 11, 1, 10, 1'b0, ec);
        send_gate(2, 12, 2, 2, 1'b0, ec);
        send_gate(0, 13, 11, 0, 1'b0, ec);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(bus_if.busy),     32'd0);
        check("arst_done",   32'(bus_if.done),     32'd0);
        check("arst_err",    32'(bus_if.err),      32'd0);
        check("arst_cnt",    32'(bus_if.gate_cnt), 32'd0);
        check("arst_rdy",    32'(bus_if.g_ready),  32'd0);
        check("arst_rd_val", 32'(bus_if.rd_val),   32'd0);
        model_clear();
        m_state = S_IDLE;
        m_code  = 0;
        m_cnt   = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int id = 0; id < NN; id++) read_chk(id, "arst");
        status_chk("arst_idle");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check({e.name, "_never_checked"}, 32'd0, 32'd1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit exceeded");
    end
endmodule
`default_nettype wire
